// File: rtl/ram32_arbiter.sv
// Round-robin arbiter sharing one single-port 32x8 RAM between two requesters.
// Latency: grant in the cycle after req is sampled; read data + rvalid one cycle after grant.
// Backpressure: one access in flight; losers hold req until their gnt pulse (max 1 access / 2 cycles).
module ram32_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_en,
    input  logic [DATA_W-1:0] ram_data_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    logic              last;
    logic              lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              win1;

    // Port 1 wins when alone, or on contention when port 0 was granted last.
    always_comb begin
        win1 = req1 & (~req0 | ~last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        lat_port  <= win1;
                        lat_we    <= win1 ? we1 : we0;
                        lat_addr  <= win1 ? addr1 : addr0;
                        lat_wdata <= win1 ? wdata1 : wdata0;
                        gnt0      <= ~win1;
                        gnt1      <= win1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    last  <= lat_port;
                    state <= IDLE;
                    if (!lat_we) begin
                        if (lat_port) begin
                            rdata1  <= ram_data_out;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= ram_data_out;
                            rvalid0 <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address and data hold their last latched values while idle; only the strobe is gated.
    assign ram_addr     = lat_addr;
    assign ram_data_in  = lat_wdata;
    assign ram_write_en = (state == ACCESS) & lat_we & ~rst;

endmodule

// File: tb/tb_ram32_arbiter.sv
// Bench for ram32_arbiter: behavioural 32x8 RAM, table of single accesses, read scoreboard,
// and hand-written sequences for contention, reset-in-access, late input changes and writes.
module tb_ram32_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, ram_write_en;
    logic [7:0] rdata0, rdata1, ram_data_in, ram_data_out;
    logic [4:0] ram_addr;

    logic [7:0] mem [32];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic       port;
        logic [7:0] data;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        bit         port;
        bit         we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[8];

    ram32_arbiter #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_write_en(ram_write_en), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en) mem[ram_addr] <= ram_data_in;
    end
    assign ram_data_out = mem[ram_addr];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Advance one cycle; mid-cycle, check exclusivity and retire any read return.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (mon_en) begin
            chk("gnt_exclusive", {31'b0, gnt0 & gnt1}, 32'd0);
            chk("rvalid_exclusive", {31'b0, rvalid0 & rvalid1}, 32'd0);
            if (rvalid0 || rvalid1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_rvalid: rvalid0=%0b rvalid1=%0b none outstanding",
                             rvalid0, rvalid1);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_port", {31'b0, rvalid1}, {31'b0, e.port});
                    chk("sb_rdata", {24'b0, (rvalid1 ? rdata1 : rdata0)}, {24'b0, e.data});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [4:0] a,
                         input logic [7:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic release_req(input bit p);
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    function automatic logic gnt_of(input bit p);
        return p ? gnt1 : gnt0;
    endfunction

    function automatic logic rvalid_of(input bit p);
        return p ? rvalid1 : rvalid0;
    endfunction

    task automatic check_reset_vals();
        chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
        chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
        chk("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
        chk("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
        chk("rst_rdata0", {24'b0, rdata0}, 32'd0);
        chk("rst_rdata1", {24'b0, rdata1}, 32'd0);
        chk("rst_ram_addr", {27'b0, ram_addr}, 32'd0);
        chk("rst_ram_data_in", {24'b0, ram_data_in}, 32'd0);
        chk("rst_ram_write_en", {31'b0, ram_write_en}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        check_reset_vals();
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    // Single access: grant exactly one cycle after sampling, rvalid the cycle after for reads.
    task automatic do_access(input bit p, input bit w, input logic [4:0] a,
                             input logic [7:0] d, input logic [7:0] e);
        drive(p, 1'b1, w, a, d);
        if (!w) sbq.push_back('{port: p, data: e});
        step();
        chk("acc_gnt", {31'b0, gnt_of(p)}, 32'd1);
        chk("acc_gnt_other", {31'b0, gnt_of(!p)}, 32'd0);
        chk("acc_ram_addr", {27'b0, ram_addr}, {27'b0, a});
        chk("acc_ram_we", {31'b0, ram_write_en}, {31'b0, w});
        if (w) chk("acc_ram_data_in", {24'b0, ram_data_in}, {24'b0, d});
        release_req(p);
        step();
        chk("acc_gnt_done", {30'b0, gnt1, gnt0}, 32'd0);
        chk("acc_rvalid", {31'b0, rvalid_of(p)}, {31'b0, !w});
        chk("acc_rvalid_other", {31'b0, rvalid_of(!p)}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        vecs[0] = '{port: 0, we: 1, addr: 5'd3,  wdata: 8'hA5, exp: 8'h00};
        vecs[1] = '{port: 0, we: 0, addr: 5'd3,  wdata: 8'h00, exp: 8'hA5};
        vecs[2] = '{port: 1, we: 1, addr: 5'd30, wdata: 8'h3C, exp: 8'h00};
        vecs[3] = '{port: 1, we: 0, addr: 5'd30, wdata: 8'h00, exp: 8'h3C};
        vecs[4] = '{port: 0, we: 0, addr: 5'd30, wdata: 8'h00, exp: 8'h3C};
        vecs[5] = '{port: 1, we: 0, addr: 5'd3,  wdata: 8'h00, exp: 8'hA5};
        vecs[6] = '{port: 0, we: 1, addr: 5'd3,  wdata: 8'h00, exp: 8'h00};
        vecs[7] = '{port: 0, we: 0, addr: 5'd3,  wdata: 8'h00, exp: 8'h00};

        do_reset();
        for (int i = 0; i < 8; i++)
            do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        // Saturated contention after reset: port 0 first, then alternate.
        do_reset();
        do_access(1, 1, 5'd1, 8'h42, 8'h00);
        do_access(1, 1, 5'd17, 8'h99, 8'h00);
        drive(0, 1, 0, 5'd1, 8'h00);
        drive(1, 1, 0, 5'd17, 8'h00);
        sbq.push_back('{port: 1'b0, data: 8'h42});
        sbq.push_back('{port: 1'b1, data: 8'h99});
        sbq.push_back('{port: 1'b0, data: 8'h42});
        sbq.push_back('{port: 1'b1, data: 8'h99});
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("rr_gnt0_c%0d", c), {31'b0, gnt0}, {31'b0, (c == 1 || c == 5)});
            chk($sformatf("rr_gnt1_c%0d", c), {31'b0, gnt1}, {31'b0, (c == 3 || c == 7)});
            chk($sformatf("rr_rvalid0_c%0d", c), {31'b0, rvalid0}, {31'b0, (c == 2 || c == 6)});
            chk($sformatf("rr_rvalid1_c%0d", c), {31'b0, rvalid1}, {31'b0, (c == 4 || c == 8)});
        end
        req0 = 0;
        req1 = 0;
        step();

        // Full address sweep: write from port 1, read back from port 0.
        for (int a = 0; a < 32; a++) begin
            d = 8'(a) ^ 8'h5A;
            do_access(1, 1, 5'(a), d, 8'h00);
        end
        for (int a = 0; a < 32; a++) begin
            d = 8'(a) ^ 8'h5A;
            do_access(0, 0, 5'(a), 8'h00, d);
        end

        // Reset in the ACCESS cycle of a write: nothing committed.
        do_access(0, 1, 5'd7, 8'h11, 8'h00);
        drive(0, 1, 1, 5'd7, 8'hFF);
        step();
        chk("rstw_gnt0", {31'b0, gnt0}, 32'd1);
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        chk("rstw_ram_we", {31'b0, ram_write_en}, 32'd0);
        step();
        check_reset_vals();
        rst = 1'b0;
        do_access(0, 0, 5'd7, 8'h00, 8'h11);

        // Reset in the ACCESS cycle of a read: dropped, rdata cleared, no rvalid.
        do_access(1, 0, 5'd7, 8'h00, 8'h11);
        drive(1, 1, 0, 5'd7, 8'h00);
        step();
        chk("rstr_gnt1", {31'b0, gnt1}, 32'd1);
        rst = 1'b1;
        req1 = 1'b0;
        step();
        check_reset_vals();
        rst = 1'b0;
        step();
        chk("rstr_no_rvalid1", {31'b0, rvalid1}, 32'd0);
        chk("rstr_rdata1", {24'b0, rdata1}, 32'd0);

        // Inputs changed during ACCESS must not affect the access in flight.
        drive(1, 1, 1, 5'd9, 8'h77);
        step();
        chk("late_gnt1", {31'b0, gnt1}, 32'd1);
        drive(1, 0, 1, 5'd10, 8'h99);
        #1;
        chk("late_ram_addr", {27'b0, ram_addr}, 32'd9);
        chk("late_ram_data_in", {24'b0, ram_data_in}, 32'h77);
        step();
        do_access(0, 0, 5'd9, 8'h00, 8'h77);
        d = 8'd10 ^ 8'h5A;
        do_access(0, 0, 5'd10, 8'h00, d);

        // A write from port 1 leaves port 0's read result alone and raises no rvalid.
        do_access(1, 1, 5'd4, 8'h3C, 8'h00);
        do_access(0, 0, 5'd4, 8'h00, 8'h3C);
        drive(1, 1, 1, 5'd5, 8'hC3);
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 1) begin
                chk("wr_gnt1", {31'b0, gnt1}, 32'd1);
                release_req(1);
            end
            chk($sformatf("wr_rdata0_c%0d", c), {24'b0, rdata0}, 32'h3C);
            chk($sformatf("wr_rvalid0_c%0d", c), {31'b0, rvalid0}, 32'd0);
            chk($sformatf("wr_rvalid1_c%0d", c), {31'b0, rvalid1}, 32'd0);
        end
        do_access(0, 0, 5'd5, 8'h00, 8'hC3);

        step();
        step();
        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram32_arbiter.md
# ram32_arbiter

Two-port round-robin arbiter that shares one 32×8 RAM between two requesters, e.g. instruction fetch on port 0 and data load/store on port 1. It latches one request at a time and drives the RAM address, data and write enable for exactly one cycle. It captures read data into a per-port register and returns it with a one-cycle valid pulse. It sits between the CPU access units and the RAM32_8 instance.

## Interface
- DATA_W, default 8 (`WORDSIZE`), data width.
- ADDR_W, default 5, address width (32 words).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request per port; held high until that port's gnt is seen.
- we0, we1  in  1  1 = write, 0 = read; valid while req is high.
- addr0, addr1  in  ADDR_W  word address.
- wdata0, wdata1  in  DATA_W  write data.
- gnt0, gnt1  out  1  one-cycle pulse in the cycle the port's access executes on the RAM.
- rdata0, rdata1  out  DATA_W  last read result for the port; holds its value between reads.
- rvalid0, rvalid1  out  1  one-cycle pulse, the cycle after a read grant.
- ram_addr  out  ADDR_W  to RAM `addr`.
- ram_data_in  out  DATA_W  to RAM `data_in`.
- ram_write_en  out  1  to RAM `write_en`.
- ram_data_out  in  DATA_W  from RAM `data_out`; combinational read of `ram_addr`.

## Operation
- FSM states are IDLE and ACCESS. The arbiter also keeps the latched request (port, we, addr, wdata) and a last-granted flag, `last`.
- IDLE:
  - If any req is high, pick the winner, latch its we/addr/wdata, and go to ACCESS.
  - If no req is high, stay in IDLE.
- ACCESS:
  - Always lasts one cycle, then returns to IDLE.
  - `last` updates to the granted port.
- Arbitration:
  - If only one req is high, that port wins.
  - If both are high, the port not equal to `last` wins.
  - `last` resets to 1, so port 0 wins the first contention.
- Outputs in ACCESS:
  - gnt of the granted port = 1; the other gnt = 0.
  - ram_addr and ram_data_in come from the latched request.
  - ram_write_en = latched we AND NOT rst.
- Outputs in IDLE:
  - gnt0 = gnt1 = 0 and ram_write_en = 0.
  - ram_addr and ram_data_in hold their last latched values (0 after reset).
- Read in ACCESS: ram_data_out is registered into the granted port's rdata at the end of ACCESS, and that port's rvalid pulses the following cycle.
- Write in ACCESS: the RAM commits at the end of ACCESS. No rvalid pulse; rdata is unchanged.
- A requester that keeps req high after seeing gnt is treated as a new request in the following IDLE cycle.
- Reset values:
  - state = IDLE, `last` = 1.
  - gnt0/1 = 0, rvalid0/1 = 0.
  - rdata0/1 = 0, latched addr/wdata = 0.
  - ram_write_en = 0.

## Timing
- A request sampled high in IDLE at edge E gets its grant (ACCESS) in the cycle following E.
- Read data: rdata is valid and rvalid is high 2 cycles after the sampling edge.
- Maximum throughput is one access per 2 cycles. With both ports saturated, grants alternate 0,1,0,1.
- req, we, addr and wdata are sampled only in IDLE. Changes during ACCESS are ignored for the access in flight.
- Reset during ACCESS:
  - ram_write_en is forced to 0 in that cycle, so no write is committed.
  - Next state is IDLE, and no rvalid pulse follows.
  - A read in flight is dropped and rdata is cleared.
- Simultaneous requests in IDLE: exactly one grant. The loser stays pending and must keep req high; it wins the next IDLE because `last` has flipped.
- gnt0 and gnt1 are never high in the same cycle. rvalid0 and rvalid1 are never high in the same cycle.

## Test plan
- Reset, then port 0 writes 0xA5 to addr 3 and then reads addr 3 -> gnt0 pulses 1 cycle after each sampled req; rdata0 = 0xA5 with rvalid0 pulsing 2 cycles after the read is sampled.
- Both ports request continuously: port 0 reads addr 1, port 1 reads addr 17, both preloaded -> grant order 0,1,0,1 with an ACCESS every 2nd cycle; rdata0 = mem[1], rdata1 = mem[17]; no gnt overlap.
- Write the full address range 0..31 from port 1 with data = addr XOR 0x5A, then read all 32 from port 0 -> every readback matches, including addr 16 and addr 31 (upper half).
- Assert rst in the ACCESS cycle of a port 0 write of 0xFF to addr 7, where addr 7 was preloaded with 0x11 -> ram_write_en = 0 that cycle; a later read of addr 7 returns 0x11; all outputs return to reset values.
- Change port 1 addr/wdata during its ACCESS cycle -> the RAM receives the values latched in IDLE; the changed values are not used.
- Write from port 1 while port 0's rdata holds 0x3C from an earlier read -> rdata0 stays 0x3C, and neither rvalid0 nor rvalid1 pulses for the write.
